// File: rtl/mccoy_pkg.sv
// Shared definitions for the McCoy 8-bit CPU control path: opcodes,
// sequencer states, instruction field positions and the PC update select.
package mccoy_pkg;

    localparam logic [2:0] OP_LI   = 3'd0;
    localparam logic [2:0] OP_JA   = 3'd1;
    localparam logic [2:0] OP_BEZ  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_LR   = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_SR   = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    // Instruction byte layout: [7:5] opcode, [4:0] immediate.
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int IMM_MSB = 4;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Update select for the program counter style registers.
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_TARGET = 2'd1,
        PC_INCR   = 2'd2
    } pc_sel_t;

    // Extract the opcode field from an instruction byte.
    function automatic logic [2:0] opcode_of(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/mccoy_pc.sv
// Program-counter style register: hold, load a target, or increment with
// natural wrap-around at 2^W. Used for both the pc and the load pointer.
module mccoy_pc
    import mccoy_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  pc_sel_t      sel,
    input  logic [W-1:0] target,
    output logic [W-1:0] value
);

    logic [W-1:0] value_r;

    // Counter register; the increment overflows from 2^W-1 back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= {W{1'b0}};
        end else begin
            case (sel)
                PC_TARGET: value_r <= target;
                PC_INCR:   value_r <= value_r + {{(W-1){1'b0}}, 1'b1};
                PC_HOLD:   value_r <= value_r;
                default:   value_r <= value_r;
            endcase
        end
    end

    assign value = value_r;

endmodule

// File: rtl/mccoy_sequencer.sv
// McCoy multi-cycle control sequencer: loads the program into instruction
// memory, then steps each instruction through FETCH, DECODE and EXEC.
module mccoy_sequencer
    import mccoy_pkg::*;
#(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            load_valid,
    input  logic [7:0]      load_data,
    output logic            load_ready,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_we,
    output logic [7:0]      imem_wdata,
    input  logic [7:0]      imem_rdata,
    output logic [2:0]      opcode,
    output logic [PC_W-1:0] imm,
    input  logic            bez,
    input  logic            ja,
    input  logic            x8_zero,
    output logic            exec_en,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_t          state_r;
    state_t          state_s;
    logic [7:0]      ir_r;
    pc_sel_t         pc_sel_s;
    pc_sel_t         ptr_sel_s;
    logic [PC_W-1:0] pc_target_s;
    logic [PC_W-1:0] pc_s;
    logic [PC_W-1:0] ptr_s;
    logic            load_fire_s;

    // A beat in the reset cycle must not reach memory.
    assign load_fire_s = (state_r == ST_LOAD) && load_valid && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a dropped run only takes effect after EXEC so an
    // instruction is never abandoned mid-flight.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (run) state_s = ST_FETCH;
                else     state_s = ST_LOAD;
            end
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: state_s = ST_EXEC;
            ST_EXEC: begin
                if (!run)                            state_s = ST_LOAD;
                else if (opcode_of(ir_r) == OP_HALT) state_s = ST_HALT;
                else                                 state_s = ST_FETCH;
            end
            ST_HALT: begin
                if (!run) state_s = ST_LOAD;
                else      state_s = ST_HALT;
            end
            default:   state_s = ST_LOAD;
        endcase
    end

    // Select how pc and load pointer advance in the current state.
    always_comb begin
        pc_sel_s    = PC_HOLD;
        ptr_sel_s   = PC_HOLD;
        pc_target_s = {PC_W{1'b0}};
        case (state_r)
            ST_LOAD: begin
                if (run) pc_sel_s = PC_TARGET;
                else     pc_sel_s = PC_HOLD;
                if (load_fire_s) ptr_sel_s = PC_INCR;
                else             ptr_sel_s = PC_HOLD;
            end
            ST_EXEC: begin
                if (ja || (bez && x8_zero)) begin
                    pc_sel_s    = PC_TARGET;
                    pc_target_s = ir_r[PC_W-1:0];
                end else begin
                    pc_sel_s    = PC_INCR;
                end
                if (!run) ptr_sel_s = PC_TARGET;
                else      ptr_sel_s = PC_HOLD;
            end
            ST_HALT: begin
                if (!run) ptr_sel_s = PC_TARGET;
                else      ptr_sel_s = PC_HOLD;
            end
            default: begin
                pc_sel_s  = PC_HOLD;
                ptr_sel_s = PC_HOLD;
            end
        endcase
    end

    // Instruction register captures memory read data during DECODE only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_r <= 8'h00;
        end else if (state_r == ST_DECODE) begin
            ir_r <= imem_rdata;
        end else begin
            ir_r <= ir_r;
        end
    end

    mccoy_pc #(.W(PC_W)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .sel    (pc_sel_s),
        .target (pc_target_s),
        .value  (pc_s)
    );

    mccoy_pc #(.W(PC_W)) u_load_ptr (
        .clk    (clk),
        .reset  (reset),
        .sel    (ptr_sel_s),
        .target ({PC_W{1'b0}}),
        .value  (ptr_s)
    );

    assign load_ready = (state_r == ST_LOAD);
    assign imem_we    = load_fire_s;
    assign imem_wdata = load_data;
    assign imem_addr  = (state_r == ST_LOAD) ? ptr_s : pc_s;
    assign opcode     = opcode_of(ir_r);
    assign imm        = ir_r[PC_W-1:0];
    assign exec_en    = (state_r == ST_EXEC);
    assign halted     = (state_r == ST_HALT);
    assign pc         = pc_s;

endmodule

// File: doc/mccoy_sequencer.md
# mccoy_sequencer

Multi-cycle control sequencer for the McCoy 8-bit CPU. It owns the program counter and instruction register, loads a program into instruction memory through a byte-wide valid/ready port, and steps each instruction through fetch, decode and execute. It sits between the top-level IO pins, the instruction memory and the opcode decoder. It presents the opcode to the decoder and consumes the decoder's branch/jump controls plus the x8 zero flag.

## Interface
- `PC_W`, default 5: program counter and immediate width; instruction memory depth is 2^PC_W.
- `clk`  input  1  system clock; all logic is rising-edge.
- `reset`  input  1  synchronous, active-high reset.
- `run`  input  1  level: 0 = load mode, 1 = execute mode.
- `load_valid`  input  1  a program byte is present on `load_data`.
- `load_data`  input  8  program byte: [7:5] opcode, [4:0] immediate.
- `load_ready`  output  1  sequencer accepts a program byte this cycle.
- `imem_addr`  output  PC_W  instruction memory address.
- `imem_we`  output  1  instruction memory write strobe.
- `imem_wdata`  output  8  instruction memory write data, equal to `load_data`.
- `imem_rdata`  input  8  synchronous-read data, valid one cycle after the address.
- `opcode`  output  3  IR[7:5], sent to the decoder.
- `imm`  output  PC_W  IR[PC_W-1:0], sent to the datapath and branch target.
- `bez`, `ja`  input  1 each  decoder controls.
- `x8_zero`  input  1  x8 register equals 0.
- `exec_en`  output  1  one-cycle datapath commit strobe that gates `writex8`/`writeReg`.
- `pc`  output  PC_W  current program counter.
- `halted`  output  1  HALT state indicator.

## Operation
- States:
  - LOAD: `load_ready`=1. `load_valid`&`load_ready` gives `imem_we`=1 and `imem_addr`=load_ptr; load_ptr then increments, wrapping from 2^PC_W-1 to 0. Overflow writes overwrite address 0 with no error.
  - FETCH: `imem_addr`=pc.
  - DECODE: IR <= `imem_rdata`.
  - EXEC: `exec_en`=1. Next pc is selected in this priority:
    - `ja` gives pc <= imm.
    - `bez` & `x8_zero` gives pc <= imm.
    - Otherwise pc <= pc+1 mod 2^PC_W.
  - HALT: `halted`=1; pc and IR are frozen.
- Transitions:
  - LOAD→FETCH when `run`=1; pc <= 0.
  - FETCH→DECODE→EXEC unconditionally.
  - From EXEC:
    - `run`=0 goes to LOAD, with load_ptr <= 0.
    - Opcode 3'b111 (unused by the decoder, reserved as HALT) goes to HALT. Its `exec_en` still pulses, but the decoder produces no writes for it.
    - Otherwise goes to FETCH.
  - HALT→LOAD when `run`=0, with load_ptr <= 0.
- `run` falling during FETCH/DECODE: the current instruction completes through EXEC, then the block enters LOAD. An instruction is never aborted mid-flight.
- `run` toggling inside LOAD without any bytes written: the program executes whatever is already in memory.
- `load_valid` outside LOAD is ignored. `load_ready`=0 and `imem_we`=0 in every other state.
- `imem_addr`:
  - FETCH: pc.
  - LOAD: load_ptr.
  - Other states: pc.

## Timing
- Reset values: state=LOAD, pc=0, load_ptr=0, IR=0 (so `opcode`=0, `imm`=0), `exec_en`=0, `imem_we`=0, `load_ready`=1, `halted`=0.
- Reset takes precedence over every event in the same cycle, including an accepted load beat; that byte is not written.
- Throughput: one instruction per 3 cycles (FETCH, DECODE, EXEC). `exec_en` is high exactly one cycle per instruction.
- Load: one byte per cycle at full rate. The memory write occurs on the same edge as the handshake.
- Branch/jump target takes effect at the next FETCH, with no bubble beyond the 3-cycle cadence.
- `x8_zero` is sampled in EXEC, before that instruction's own x8 write lands.
- From `run` rising in LOAD to the first `exec_en`: 4 cycles (LOAD→FETCH edge, then FETCH, DECODE, EXEC).

## Structure
- `mccoy_pkg` holds:
  - Opcode constants (LI=0, JA=1, BEZ=2, ADD=3, LR=4, NOT=5, SR=6, HALT=7).
  - The state enum {LOAD, FETCH, DECODE, EXEC, HALT}.
  - The instruction field slice positions.
- Sub-module `mccoy_pc`: a PC_W register with a load-target/increment/hold select and wrap-around. It is reused for load_ptr.
- The decoder stays a separate instance at the top level. The sequencer does not embed it.

## Test plan
- Reset mid-load: assert `reset` together with an accepted beat → no `imem_we`; next cycle pc=0, load_ptr=0, `load_ready`=1.
- Load and run: stream bytes 0x05, 0x67, 0xE0 with `load_valid` held high → writes to addresses 0, 1, 2 in consecutive cycles. Then `run`=1 → `exec_en` pulses at cycles 4, 7, 10 after the edge, and `halted`=1 after the third instruction.
- Jump: byte 0x23 (ja 3) at addr 0 → the next fetch address is 3; wrap check: pc=31 non-branch → the next fetch address is 0.
- BEZ: 0x44 at pc 0 with `x8_zero`=1 → next pc=4. With `x8_zero`=0 → next pc=1.
- `run` dropped during DECODE → that instruction's `exec_en` still fires once, then the block is in LOAD with `load_ready`=1 and load_ptr=0.
- Load overflow: write 33 bytes → the 33rd byte overwrites address 0; reading it back by running shows the new byte's opcode.
